// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one downstream resource between N requesters.
// Registered one-hot grant plus binary mux select, with lock-based bursts capped at MAX_BURST beats.
module mux_rr_arbiter #(
  parameter int N         = 5,
  parameter int SEL_W     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     lock,
  input  logic             out_ready,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [N-1:0]     sel_hit;
  logic [N-1:0]     win_onehot;
  logic [N-1:0]     search_mask;
  logic [SEL_W-1:0] search_start;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W:0]   win_pick;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;
  logic             req_g;
  logic             lock_g;
  logic             beat;
  logic             at_cap;
  logic             release_g;

  // First set bit of mask scanning start, start+1, ... modulo N; returns {found, index}.
  function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] mask,
                                             input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] idx;
    int               pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == pos) && mask[j]) begin
          found = 1'b1;
          idx   = SEL_W'(j);
        end
      end
    end
    return {found, idx};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_decode
      assign sel_hit[gi]    = (sel_q == SEL_W'(gi));
      assign win_onehot[gi] = (win_idx == SEL_W'(gi));
    end
  endgenerate

  assign req_g     = |(req & sel_hit);
  assign lock_g    = |(lock & sel_hit);
  assign busy      = (state_q == BUSY);
  assign out_valid = busy & req_g;
  assign beat      = out_valid & out_ready;
  assign at_cap    = (burst_cnt_q == LAST_BEAT);
  assign release_g = ~req_g | (beat & (~lock_g | at_cap));
  assign next_ptr  = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);

  // On release the current holder is masked out so a lone requester cannot re-win immediately.
  assign search_mask  = busy ? (req & ~gnt_q) : req;
  assign search_start = busy ? next_ptr : rr_ptr_q;
  assign win_pick     = rr_pick(search_mask, search_start);
  assign win_found    = win_pick[SEL_W];
  assign win_idx      = win_pick[SEL_W-1:0];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = BUSY;
          gnt_d       = win_onehot;
          sel_d       = win_idx;
          burst_cnt_d = '0;
        end
      end
      BUSY: begin
        if (release_g) begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          if (win_found) begin
            gnt_d = win_onehot;
            sel_d = win_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (beat) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected beat selects are queued by the stimulus
// and popped by a monitor each time a beat is accepted by the resource.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] lock;
  logic       out_ready;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  mux_rr_arbiter #(.N(5), .SEL_W(3), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; out_ready = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  // Monitor: every accepted beat must match the next queued select.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        $display("beat sel=%0d gnt=%b", sel, gnt);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected got sel=%0d exp=none", sel);
        end else begin
          e = exp_q.pop_front();
          chk("beat_sel", int'(sel), e);
          chk("beat_gnt", int'(gnt), 1 << e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all requesters active.
    rst = 1'b1; req = 5'b11111; lock = '0; out_ready = 1'b0;
    step(2);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);

    // Round robin across all five, one beat per cycle.
    rst = 1'b0; out_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(0);
    step(1);
    chk("first_grant_gnt", int'(gnt), 1);
    chk("first_grant_sel", int'(sel), 0);
    for (int i = 0; i < 6; i++) begin
      chk("rr_no_bubble", int'(out_valid), 1);
      step(1);
    end
    req = '0; out_ready = 1'b0;
    step(2);
    chk("rr_idle_busy", int'(busy), 0);

    // Burst cap: locked req0 gets exactly four beats, then req1.
    do_reset();
    req = 5'b00011; lock = 5'b00001; out_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(1);
    step(1);
    chk("burst_first_sel", int'(sel), 0);
    step(3);
    chk("burst_cnt_cap", int'(dut.burst_cnt_q), 3);
    chk("burst_still_sel", int'(sel), 0);
    step(1);
    chk("burst_handoff_sel", int'(sel), 1);
    step(1);
    req = '0; lock = '0; out_ready = 1'b0;
    step(2);

    // Backpressure on req2: grant stable, no beats counted.
    do_reset();
    req = 5'b00100;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_gnt", int'(gnt), 5'b00100);
      chk("bp_sel", int'(sel), 2);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_burst_cnt", int'(dut.burst_cnt_q), 0);
      step(1);
    end
    out_ready = 1'b1;
    exp_q.push_back(2);
    step(1);
    req = '0; out_ready = 1'b0;
    chk("bp_release_busy", int'(busy), 0);
    chk("bp_release_gnt", int'(gnt), 0);
    chk("bp_idle_sel_hold", int'(sel), 2);

    // Abandon: req3 drops while req1 waits.
    do_reset();
    req = 5'b01000;
    step(1);
    chk("abandon_pre_sel", int'(sel), 3);
    req = 5'b00010;
    step(1);
    chk("abandon_sel", int'(sel), 1);
    chk("abandon_gnt", int'(gnt), 5'b00010);
    chk("abandon_rr_ptr", int'(dut.rr_ptr_q), 4);
    chk("abandon_burst_cnt", int'(dut.burst_cnt_q), 0);
    out_ready = 1'b1;
    exp_q.push_back(1);
    step(1);
    req = '0; out_ready = 1'b0;
    chk("abandon_rr_ptr_after", int'(dut.rr_ptr_q), 2);

    // Reset in the middle of a locked burst on req4.
    req = 5'b10000; lock = 5'b10000; out_ready = 1'b1;
    exp_q.push_back(4); exp_q.push_back(4);
    step(1);
    chk("midrst_sel", int'(sel), 4);
    step(2);
    chk("midrst_pre_rr_ptr", int'(dut.rr_ptr_q), 2);
    rst = 1'b1;
    step(1);
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_rr_ptr", int'(dut.rr_ptr_q), 0);
    chk("midrst_burst_cnt", int'(dut.burst_cnt_q), 0);
    rst = 1'b0; req = '0; lock = '0; out_ready = 1'b0;
    step(2);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
